// File: rtl/pll_pkg.sv
// ============================================================================
// Module  : pll_pkg
// Purpose : Shared state encoding and default timing for the PLL supervisor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int unsigned CLKIN_HZ = 27_000_000;

    // 1 ms lock window and 100 us stability window at the reference clock
    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = CLKIN_HZ / 1_000;
    localparam int unsigned DEF_STABLE_CYCLES = CLKIN_HZ / 10_000;

    localparam logic [7:0] FAULT_CNT_MAX = 8'hFF;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == FAULT_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module  : sync2
// Purpose : Generic two-flop single-bit synchroniser, clears to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_rst_ctrl.sv
// ============================================================================
// Module  : pll_rst_ctrl
// Purpose : rPLL reset sequencer and lock supervisor with fault counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_rst_ctrl
    import pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic [7:0] timeout_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic             lock_s;

    pll_state_e       state_d;
    pll_state_e       state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       timeout_cnt_d;
    logic [7:0]       timeout_cnt_q;
    logic [7:0]       loss_cnt_d;
    logic [7:0]       loss_cnt_q;
    logic             pll_reset_d;
    logic             pll_reset_q;
    logic             sys_rst_n_d;
    logic             sys_rst_n_q;

    sync2 u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_lock_i),
        .q_o     (lock_s)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        timeout_cnt_d = timeout_cnt_q;
        loss_cnt_d    = loss_cnt_q;

        case (state_q)
            RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // a lock seen on the final timeout cycle still counts as lock
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = RESET;
                    timeout_cnt_d = sat_inc8(timeout_cnt_q);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d    = RESET;
                    loss_cnt_d = sat_inc8(loss_cnt_q);
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // outputs follow the next state so they update on the same edge
        pll_reset_d = (state_d == RESET);
        sys_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= RESET;
            cnt_q         <= '0;
            timeout_cnt_q <= 8'd0;
            loss_cnt_q    <= 8'd0;
            pll_reset_q   <= 1'b1;
            sys_rst_n_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            pll_reset_q   <= pll_reset_d;
            sys_rst_n_q   <= sys_rst_n_d;
        end
    end

    assign pll_reset_o   = pll_reset_q;
    assign sys_rst_n_o   = sys_rst_n_q;
    assign timeout_cnt_o = timeout_cnt_q;
    assign loss_cnt_o    = loss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_rst_ctrl.sv
// ============================================================================
// Module  : tb_pll_rst_ctrl
// Purpose : Self-checking bench for pll_rst_ctrl against a phase-timeline model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_rst_ctrl;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int ST_C  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       lock  = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic [7:0] tcnt;
    logic [7:0] lcnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    pll_rst_ctrl #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (ST_C)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pll_lock_i    (lock),
        .pll_reset_o   (pll_reset),
        .sys_rst_n_o   (sys_rst_n),
        .timeout_cnt_o (tcnt),
        .loss_cnt_o    (lcnt)
    );

    always #5 clk = ~clk;

    // Model: each phase remembers the edge number it was entered on; the
    // FSM sees the lock input as it was sampled two edges earlier.
    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;

    int m_phase    = PH_PULSE;
    int m_entry    = 0;
    int m_edge     = 0;
    int m_timeouts = 0;
    int m_losses   = 0;
    bit m_seen;
    bit m_hist[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase    = PH_PULSE;
            m_entry    = 0;
            m_edge     = 0;
            m_timeouts = 0;
            m_losses   = 0;
            m_hist.delete();
        end else begin
            m_edge = m_edge + 1;
            m_seen = (m_hist.size() == 2) ? m_hist[0] : 1'b0;
            m_hist.push_back(lock);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
            case (m_phase)
                PH_PULSE: if (m_edge - m_entry == RST_C) begin
                    m_phase = PH_WAIT; m_entry = m_edge;
                end
                PH_WAIT: if (m_seen) begin
                    m_phase = PH_SETTLE; m_entry = m_edge;
                end else if (m_edge - m_entry == TO_C) begin
                    m_phase = PH_PULSE; m_entry = m_edge;
                    if (m_timeouts < 255) m_timeouts = m_timeouts + 1;
                end
                PH_SETTLE: if (!m_seen) begin
                    m_phase = PH_WAIT; m_entry = m_edge;
                end else if (m_edge - m_entry == ST_C) begin
                    m_phase = PH_RUN; m_entry = m_edge;
                end
                default: if (!m_seen) begin
                    m_phase = PH_PULSE; m_entry = m_edge;
                    if (m_losses < 255) m_losses = m_losses + 1;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("model pll_reset_o",   32'(pll_reset), 32'(m_phase == PH_PULSE));
            chk("model sys_rst_n_o",   32'(sys_rst_n), 32'(m_phase == PH_RUN));
            chk("model timeout_cnt_o", 32'(tcnt),      32'(m_timeouts));
            chk("model loss_cnt_o",    32'(lcnt),      32'(m_losses));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // reset changes sit 2 ns after a falling edge, clear of both clock edges
    task automatic apply_reset(input logic lk);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        lock   = lk;
        cmp_en = 1'b1;
        edges(2);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: lock tied high from reset
        apply_reset(1'b1);
        chk("t1 reset pll_reset", 32'(pll_reset), 32'd1);
        chk("t1 reset sys_rst_n", 32'(sys_rst_n), 32'd0);
        edges(3);
        chk("t1 pll_reset edge3", 32'(pll_reset), 32'd1);
        edges(1);
        chk("t1 pll_reset edge4", 32'(pll_reset), 32'd0);
        edges(8);
        chk("t1 sys_rst_n edge12", 32'(sys_rst_n), 32'd0);
        edges(1);
        chk("t1 sys_rst_n edge13", 32'(sys_rst_n), 32'd1);
        chk("t1 timeout_cnt", 32'(tcnt), 32'd0);
        chk("t1 loss_cnt", 32'(lcnt), 32'd0);

        // 2: lock held low, PLL re-pulsed every 24 cycles
        apply_reset(1'b0);
        edges(23);
        chk("t2 timeout edge23", 32'(tcnt), 32'd0);
        edges(1);
        chk("t2 timeout edge24", 32'(tcnt), 32'd1);
        chk("t2 pll_reset edge24", 32'(pll_reset), 32'd1);
        edges(4);
        chk("t2 pll_reset edge28", 32'(pll_reset), 32'd0);
        edges(20);
        chk("t2 timeout edge48", 32'(tcnt), 32'd2);
        edges(24);
        chk("t2 timeout edge72", 32'(tcnt), 32'd3);

        // 3: two-cycle lock drop while settling
        apply_reset(1'b1);
        edges(7);
        lock = 1'b0;
        edges(2);
        lock = 1'b1;
        edges(2);
        chk("t3 no pll pulse edge11", 32'(pll_reset), 32'd0);
        edges(8);
        chk("t3 sys_rst_n edge19", 32'(sys_rst_n), 32'd0);
        edges(1);
        chk("t3 sys_rst_n edge20", 32'(sys_rst_n), 32'd1);

        // 4: one-cycle lock drop in RUN
        edges(4);
        lock = 1'b0;
        edges(1);
        lock = 1'b1;
        edges(1);
        chk("t4 sys_rst_n edge26", 32'(sys_rst_n), 32'd1);
        edges(1);
        chk("t4 sys_rst_n edge27", 32'(sys_rst_n), 32'd0);
        chk("t4 pll_reset edge27", 32'(pll_reset), 32'd1);
        chk("t4 loss_cnt edge27", 32'(lcnt), 32'd1);
        edges(12);
        chk("t4 sys_rst_n edge39", 32'(sys_rst_n), 32'd0);
        edges(1);
        chk("t4 sys_rst_n edge40", 32'(sys_rst_n), 32'd1);
        chk("t4 loss_cnt edge40", 32'(lcnt), 32'd1);

        // 5: more than 255 timeouts
        apply_reset(1'b0);
        edges(6119);
        chk("t5 timeout edge6119", 32'(tcnt), 32'd254);
        edges(1);
        chk("t5 timeout edge6120", 32'(tcnt), 32'd255);
        edges(1200);
        chk("t5 timeout saturated", 32'(tcnt), 32'd255);

        // 6: asynchronous reset in RUN, then in STABLE
        lock = 1'b1;
        edges(30);
        chk("t6 in run sys_rst_n", 32'(sys_rst_n), 32'd1);
        chk("t6 in run timeout", 32'(tcnt), 32'd255);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 run async pll_reset", 32'(pll_reset), 32'd1);
        chk("t6 run async sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("t6 run async timeout", 32'(tcnt), 32'd0);
        chk("t6 run async loss", 32'(lcnt), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        edges(6);
        chk("t6 stable pll_reset", 32'(pll_reset), 32'd0);
        chk("t6 stable sys_rst_n", 32'(sys_rst_n), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 stable async pll_reset", 32'(pll_reset), 32'd1);
        chk("t6 stable async sys_rst_n", 32'(sys_rst_n), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        edges(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
